stack_engine: RTL and testbench

STACK_ENGINE -- requirements
Module: stack_engine

---
 rtl/stack_pkg.sv | 20 ++
 rtl/stack_ram.sv | 52 +++++
 rtl/stack_engine.sv | 102 ++++++++++
 tb/tb_stack_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants, operation encoding and preload helper for the stack engine.
package stack_pkg;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_DEPTH    = 32;
   localparam int unsigned PRELOAD_CNT  = 7;
   localparam int unsigned PRELOAD_STEP = 16;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_REPLACE
   } stack_op_e;

   function automatic int unsigned preload_value(input int unsigned idx);
      return (idx < PRELOAD_CNT) ? (idx + 1) * PRELOAD_STEP : 0;
   endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: stack/frame write lanes, combinational top read, registered read-old port.
// With STACK_ENGINE_PRELOAD_EN defined, reset loads the preload pattern into every entry.
module stack_ram
   import stack_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stack_we,
   input  logic [AW-1:0]     stack_addr,
   input  logic [DATA_W-1:0] stack_wdata,
   input  logic              frame_we,
   input  logic [AW-1:0]     frame_addr,
   input  logic [DATA_W-1:0] frame_wdata,
   input  logic [AW-1:0]     top_addr,
   output logic [DATA_W-1:0] top_q,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_q
);

   logic [DATA_W-1:0] mem [DEPTH];

`ifdef STACK_ENGINE_PRELOAD_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= DATA_W'(preload_value(i));
         end
      end else begin
         if (frame_we) mem[frame_addr] <= frame_wdata;
         if (stack_we) mem[stack_addr] <= stack_wdata;
      end
   end
`else
   // Callers gate both enables with reset, so no reset term is needed here.
   always_ff @(posedge clock) begin
      if (frame_we) mem[frame_addr] <= frame_wdata;
      if (stack_we) mem[stack_addr] <= stack_wdata;
   end
`endif

   assign top_q = mem[top_addr];

   always_ff @(posedge clock) begin
      if (reset) rd_q <= '0;
      else       rd_q <= mem[rd_addr];
   end

endmodule

// File: rtl/stack_engine.sv
// Hardware stack with pointer, sticky error flags and frame read/write access.
// Optional STACK_ENGINE_PRELOAD_EN: reset preloads entries 0..6 and sets esp to 7.
module stack_engine
   import stack_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned PTR_W  = $clog2(DEPTH) + 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [DATA_W-1:0]  push_data,
   input  logic               wr_en,
   input  logic [PTR_W-2:0]   wr_addr,
   input  logic [DATA_W-1:0]  wr_data,
   input  logic [PTR_W-2:0]   rd_addr,
   output logic [DATA_W-1:0]  top_data,
   output logic [DATA_W-1:0]  rd_data,
   output logic [PTR_W-1:0]   esp,
   output logic               full,
   output logic               empty,
   output logic               overflow,
   output logic               underflow
);

   localparam int unsigned      AW      = PTR_W - 1;
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
`ifdef STACK_ENGINE_PRELOAD_EN
   localparam logic [PTR_W-1:0] RESET_ESP = PTR_W'(PRELOAD_CNT);
`else
   localparam logic [PTR_W-1:0] RESET_ESP = '0;
`endif

   stack_op_e         op;
   logic [PTR_W-1:0]  esp_m1;
   logic              stack_we;
   logic [AW-1:0]     stack_addr;
   logic              frame_we;
   logic              ovf_set;
   logic              unf_set;
   logic [DATA_W-1:0] top_q;

   assign full   = (esp == DEPTH_P);
   assign empty  = (esp == '0);
   assign esp_m1 = esp - PTR_W'(1);

   // push&pop on an empty stack falls through to a plain push.
   always_comb begin
      op = OP_NONE;
      if (!reset) begin
         if (push && pop && !empty)      op = OP_REPLACE;
         else if (push && !full)         op = OP_PUSH;
         else if (pop && !push && !empty) op = OP_POP;
      end
   end

   assign stack_we   = (op == OP_PUSH) || (op == OP_REPLACE);
   assign stack_addr = (op == OP_REPLACE) ? esp_m1[AW-1:0] : esp[AW-1:0];
   assign frame_we   = wr_en && !reset && !(stack_we && (wr_addr == stack_addr));
   assign ovf_set    = !reset && push && !pop && full;
   assign unf_set    = !reset && pop && !push && empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         esp       <= RESET_ESP;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         unique case (op)
            OP_PUSH: esp <= esp + PTR_W'(1);
            OP_POP:  esp <= esp_m1;
            default: esp <= esp;
         endcase
         overflow  <= overflow  | ovf_set;
         underflow <= underflow | unf_set;
      end
   end

   stack_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clock       (clock),
      .reset       (reset),
      .stack_we    (stack_we),
      .stack_addr  (stack_addr),
      .stack_wdata (push_data),
      .frame_we    (frame_we),
      .frame_addr  (wr_addr),
      .frame_wdata (wr_data),
      .top_addr    (esp_m1[AW-1:0]),
      .top_q       (top_q),
      .rd_addr     (rd_addr),
      .rd_q        (rd_data)
   );

   assign top_data = empty ? '0 : top_q;

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: directed scenarios plus randomized traffic
// against an array-based stack model. Builds with or without STACK_ENGINE_PRELOAD_EN.
module tb_stack_engine;

   localparam int unsigned DATA_W = 16;
`ifdef STACK_ENGINE_PRELOAD_EN
   localparam int unsigned DEPTH     = 8;
   localparam int          RESET_ESP = 7;
`else
   localparam int unsigned DEPTH     = 4;
   localparam int          RESET_ESP = 0;
`endif
   localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
   localparam int unsigned AW    = PTR_W - 1;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              push = 1'b0;
   logic              pop = 1'b0;
   logic [DATA_W-1:0] push_data = '0;
   logic              wr_en = 1'b0;
   logic [AW-1:0]     wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic [AW-1:0]     rd_addr = '0;
   logic [DATA_W-1:0] top_data;
   logic [DATA_W-1:0] rd_data;
   logic [PTR_W-1:0]  esp;
   logic              full;
   logic              empty;
   logic              overflow;
   logic              underflow;

   int checks = 0;
   int errors = 0;

   // Reference model: plain array plus an entry count.
   logic [DATA_W-1:0] m_mem [DEPTH];
   int                m_esp = 0;
   bit                m_ovf = 0;
   bit                m_unf = 0;
   logic [DATA_W-1:0] m_rd  = '0;

   stack_engine #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr   (rd_addr),
      .top_data  (top_data),
      .rd_data   (rd_data),
      .esp       (esp),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clock = ~clock;

   function automatic logic [DATA_W-1:0] exp_top();
      return (m_esp > 0) ? m_mem[m_esp-1] : '0;
   endfunction

   // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
   task automatic step(input bit rst, input bit psh, input bit pp, input logic [DATA_W-1:0] pd,
                       input bit we, input logic [AW-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic [AW-1:0] ra);
      reset = rst; push = psh; pop = pp; push_data = pd;
      wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
      if (rst) begin
         m_esp = RESET_ESP; m_rd = '0; m_ovf = 0; m_unf = 0;
`ifdef STACK_ENGINE_PRELOAD_EN
         for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = (i < 7) ? DATA_W'((i + 1) * 16) : '0;
`endif
      end else begin
         m_rd = m_mem[ra];
         if (we) m_mem[wa] = wd;
         if (psh && pp && m_esp > 0) m_mem[m_esp-1] = pd;
         else if (psh && m_esp < int'(DEPTH)) begin m_mem[m_esp] = pd; m_esp++; end
         else if (psh) m_ovf = 1;
         else if (pp && m_esp > 0) m_esp--;
         else if (pp) m_unf = 1;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input logic [AW-1:0] ra);
      step(0, 0, 0, '0, 0, '0, '0, ra);
   endtask

   task automatic do_push(input logic [DATA_W-1:0] d);
      step(0, 1, 0, d, 0, '0, '0, '0);
   endtask

   // Reset, drain any preloaded entries, then fill memory with known random data.
   task automatic go_empty();
      step(1, 0, 0, '0, 0, '0, '0, '0);
      for (int i = 0; i < int'(DEPTH) && m_esp > 0; i++) step(0, 0, 1, '0, 0, '0, '0, '0);
      for (int a = 0; a < int'(DEPTH); a++) step(0, 0, 0, '0, 1, AW'(a), DATA_W'($urandom), '0);
   endtask

`ifdef STACK_ENGINE_PRELOAD_EN
   task automatic test_preload();
      step(1, 0, 0, '0, 0, '0, '0, '0);
      checks++;
      if (esp !== PTR_W'(7) || top_data !== DATA_W'(16'h70)) begin
         errors++;
         $display("FAIL preload_state esp=%0d top=%h expected esp=7 top=0070", esp, top_data);
      end
      idle('0);
      checks++;
      if (rd_data !== DATA_W'(16'h10)) begin
         errors++;
         $display("FAIL preload_rd rd_data=%h expected 0010", rd_data);
      end
   endtask
`endif

   task automatic test_reset();
      step(1, 1, 0, 16'hDEAD, 1, '0, 16'hBEEF, '0);
      checks++;
      if ({esp, overflow, underflow, rd_data} !== {PTR_W'(RESET_ESP), 1'b0, 1'b0, DATA_W'(0)}) begin
         errors++;
         $display("FAIL reset_state esp=%0d ovf=%b unf=%b rd=%h expected esp=%0d ovf=0 unf=0 rd=0",
                  esp, overflow, underflow, rd_data, RESET_ESP);
      end
      checks++;
      if ({full, empty} !== {1'b0, RESET_ESP == 0}) begin
         errors++;
         $display("FAIL reset_flags full=%b empty=%b expected full=0 empty=%b", full, empty, RESET_ESP == 0);
      end
   endtask

   task automatic test_push_pop();
      go_empty();
      do_push(16'h000A); do_push(16'h000B); do_push(16'h000C);
      checks++;
      if (esp !== PTR_W'(3) || top_data !== DATA_W'(16'h000C)) begin
         errors++;
         $display("FAIL push3 esp=%0d top=%h expected esp=3 top=000c", esp, top_data);
      end
      step(0, 0, 1, '0, 0, '0, '0, '0);
      checks++;
      if (esp !== PTR_W'(2) || top_data !== DATA_W'(16'h000B)) begin
         errors++;
         $display("FAIL pop1 esp=%0d top=%h expected esp=2 top=000b", esp, top_data);
      end
   endtask

   task automatic test_overflow();
      go_empty();
      for (int i = 0; i <= int'(DEPTH); i++) do_push(DATA_W'(16'h0100 + i));
      checks++;
      if (esp !== PTR_W'(DEPTH) || full !== 1'b1 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow esp=%0d full=%b ovf=%b expected esp=%0d full=1 ovf=1",
                  esp, full, overflow, DEPTH);
      end
      idle(AW'(3));
      checks++;
      if (rd_data !== DATA_W'(16'h0103)) begin
         errors++;
         $display("FAIL overflow_mem3 rd_data=%h expected 0103", rd_data);
      end
   endtask

   task automatic test_underflow();
      go_empty();
      step(0, 0, 1, '0, 0, '0, '0, '0);
      checks++;
      if (esp !== '0 || underflow !== 1'b1) begin
         errors++;
         $display("FAIL underflow esp=%0d unf=%b expected esp=0 unf=1", esp, underflow);
      end
      for (int i = 0; i < 10; i++) idle('0);
      checks++;
      if (underflow !== 1'b1) begin
         errors++;
         $display("FAIL underflow_sticky unf=%b expected 1", underflow);
      end
      step(1, 0, 0, '0, 0, '0, '0, '0);
      checks++;
      if (underflow !== 1'b0) begin
         errors++;
         $display("FAIL underflow_reset unf=%b expected 0", underflow);
      end
   endtask

   task automatic test_replace();
      go_empty();
      do_push(16'h0011); do_push(16'h0022);
      step(0, 1, 1, 16'h0055, 0, '0, '0, '0);
      checks++;
      if (esp !== PTR_W'(2) || top_data !== DATA_W'(16'h0055)) begin
         errors++;
         $display("FAIL replace_top esp=%0d top=%h expected esp=2 top=0055", esp, top_data);
      end
      go_empty();
      step(0, 1, 1, 16'h0066, 0, '0, '0, '0);
      checks++;
      if (esp !== PTR_W'(1) || underflow !== 1'b0 || top_data !== DATA_W'(16'h0066)) begin
         errors++;
         $display("FAIL replace_empty esp=%0d unf=%b top=%h expected esp=1 unf=0 top=0066",
                  esp, underflow, top_data);
      end
   endtask

   task automatic test_collision();
      logic [DATA_W-1:0] old2;
      go_empty();
      do_push(16'h0033);
      step(0, 1, 0, 16'h0077, 1, AW'(1), 16'h0099, '0);
      idle(AW'(1));
      checks++;
      if (rd_data !== DATA_W'(16'h0077)) begin
         errors++;
         $display("FAIL collision rd_data=%h expected 0077", rd_data);
      end
      old2 = m_mem[2];
      step(0, 0, 0, '0, 1, AW'(2), 16'h0ABC, AW'(2));
      checks++;
      if (rd_data !== old2) begin
         errors++;
         $display("FAIL read_old rd_data=%h expected %h", rd_data, old2);
      end
      idle(AW'(2));
      checks++;
      if (rd_data !== DATA_W'(16'h0ABC)) begin
         errors++;
         $display("FAIL read_new rd_data=%h expected 0abc", rd_data);
      end
   endtask

   task automatic test_random();
      go_empty();
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              DATA_W'($urandom), $urandom_range(0, 3) == 0, AW'($urandom), DATA_W'($urandom),
              AW'($urandom));
         checks++;
         if ({esp, full, empty, overflow, underflow} !==
             {PTR_W'(m_esp), m_esp == int'(DEPTH), m_esp == 0, m_ovf, m_unf}) begin
            errors++;
            $display("FAIL rand_state n=%0d esp=%0d f=%b e=%b o=%b u=%b expected esp=%0d o=%b u=%b",
                     n, esp, full, empty, overflow, underflow, m_esp, m_ovf, m_unf);
         end
         checks++;
         if (top_data !== exp_top() || rd_data !== m_rd) begin
            errors++;
            $display("FAIL rand_data n=%0d top=%h rd=%h expected top=%h rd=%h",
                     n, top_data, rd_data, exp_top(), m_rd);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
`ifdef STACK_ENGINE_PRELOAD_EN
      test_preload();
`endif
      test_reset();
      test_push_pop();
      test_overflow();
      test_underflow();
      test_replace();
      test_collision();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
